// File: rtl/board_renderer_pkg.sv
// Shared constants for the board renderer: 640x480@60 timing, palette and playfield geometry.
package board_renderer_pkg;

    localparam int unsigned CNT_W        = 10;
    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned V_TOTAL      = 525;
    localparam int unsigned H_VISIBLE    = 640;
    localparam int unsigned V_VISIBLE    = 480;
    localparam int unsigned H_SYNC_START = 656;
    localparam int unsigned H_SYNC_END   = 751;
    localparam int unsigned V_SYNC_START = 490;
    localparam int unsigned V_SYNC_END   = 491;

    localparam int unsigned BOARD_W    = 10;
    localparam int unsigned BOARD_H    = 20;
    localparam int unsigned BOARD_BITS = BOARD_W * BOARD_H;
    localparam int unsigned SCORE_W    = 8;
    localparam int unsigned FRAME_W    = 10;
    localparam int unsigned BORDER_PX  = 4;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t COL_CYAN   = '{r: 4'h0, g: 4'hF, b: 4'hF};
    localparam rgb_t COL_GREY   = '{r: 4'h2, g: 4'h2, b: 4'h2};
    localparam rgb_t COL_WHITE  = '{r: 4'hF, g: 4'hF, b: 4'hF};
    localparam rgb_t COL_YELLOW = '{r: 4'hF, g: 4'hF, b: 4'h0};
    localparam rgb_t COL_BLACK  = '{r: 4'h0, g: 4'h0, b: 4'h0};

endpackage

// File: rtl/board_renderer_vga_timing.sv
// Free-running 800x525 raster counters with raw (unregistered) sync, enable and frame strobe.
module vga_timing
    import board_renderer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             hsync_c,
    output logic             vsync_c,
    output logic             de_c,
    output logic             frame_start_c
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (h == CNT_W'(H_TOTAL - 1)) begin
            h <= '0;
            v <= (v == CNT_W'(V_TOTAL - 1)) ? '0 : v + CNT_W'(1);
        end else begin
            h <= h + CNT_W'(1);
        end
    end

    assign hsync_c       = !((h >= CNT_W'(H_SYNC_START)) && (h <= CNT_W'(H_SYNC_END)));
    assign vsync_c       = !((v >= CNT_W'(V_SYNC_START)) && (v <= CNT_W'(V_SYNC_END)));
    assign de_c          = (h < CNT_W'(H_VISIBLE)) && (v < CNT_W'(V_VISIBLE));
    // First blanked line: safe point to snapshot game state for the next frame.
    assign frame_start_c = (h == '0) && (v == CNT_W'(V_VISIBLE));

endmodule

// File: rtl/board_renderer.sv
// Renders the playfield, its border and a binary score strip onto the VGA raster.
module board_renderer
    import board_renderer_pkg::*;
#(
    parameter int unsigned CELL_PX  = 16,
    parameter int unsigned ORIGIN_X = 240,
    parameter int unsigned ORIGIN_Y = 80,
    parameter int unsigned SCORE_X  = 432
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BOARD_BITS-1:0] board,
    input  logic [SCORE_W-1:0]    score,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [3:0]            red,
    output logic [3:0]            green,
    output logic [3:0]            blue,
    output logic [FRAME_W-1:0]    framenumber
);

    localparam int unsigned CELL_SH = $clog2(CELL_PX);
    localparam int unsigned IDX_W   = $clog2(BOARD_BITS);
    localparam int BX0 = int'(ORIGIN_X);
    localparam int BX1 = BX0 + int'(BOARD_W * CELL_PX);
    localparam int BY0 = int'(ORIGIN_Y);
    localparam int BY1 = BY0 + int'(BOARD_H * CELL_PX);
    localparam int BP  = int'(BORDER_PX);
    localparam int SX0 = int'(SCORE_X);
    localparam int SX1 = SX0 + int'(SCORE_W * CELL_PX);
    localparam int SY1 = BY0 + int'(CELL_PX);

    logic [CNT_W-1:0]      h;
    logic [CNT_W-1:0]      v;
    logic                  hsync_c;
    logic                  vsync_c;
    logic                  de_c;
    logic                  frame_start_c;
    logic [BOARD_BITS-1:0] shadow_board;
    logic [SCORE_W-1:0]    shadow_score;

    int               hi;
    int               vi;
    logic             in_board_c;
    logic             in_border_c;
    logic             in_score_c;
    logic [3:0]       cx_c;
    logic [4:0]       cy_c;
    logic [2:0]       box_c;
    logic [IDX_W-1:0] cell_idx_c;
    rgb_t             pix_c;

    vga_timing u_timing (
        .clk           (clk),
        .rst_n         (rst_n),
        .h             (h),
        .v             (v),
        .hsync_c       (hsync_c),
        .vsync_c       (vsync_c),
        .de_c          (de_c),
        .frame_start_c (frame_start_c)
    );

    // Region decode and colour select; priority board > border > score > background.
    always_comb begin
        hi          = int'(h);
        vi          = int'(v);
        in_board_c  = (hi >= BX0) && (hi < BX1) && (vi >= BY0) && (vi < BY1);
        in_border_c = (hi >= BX0 - BP) && (hi < BX1 + BP) &&
                      (vi >= BY0 - BP) && (vi < BY1 + BP) && !in_board_c;
        in_score_c  = (hi >= SX0) && (hi < SX1) && (vi >= BY0) && (vi < SY1);
        cx_c        = 4'((h - CNT_W'(ORIGIN_X)) >> CELL_SH);
        cy_c        = 5'((v - CNT_W'(ORIGIN_Y)) >> CELL_SH);
        box_c       = 3'((h - CNT_W'(SCORE_X)) >> CELL_SH);
        cell_idx_c  = IDX_W'(int'(cx_c) * int'(BOARD_H) + int'(cy_c));
        pix_c       = COL_BLACK;
        if (!de_c) begin
            pix_c = COL_BLACK;
        end else if (in_board_c) begin
            pix_c = shadow_board[cell_idx_c] ? COL_CYAN : COL_GREY;
        end else if (in_border_c) begin
            pix_c = COL_WHITE;
        end else if (in_score_c) begin
            // Box 0 is leftmost and shows the score MSB.
            pix_c = shadow_score[~box_c] ? COL_YELLOW : COL_GREY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            de           <= 1'b0;
            red          <= '0;
            green        <= '0;
            blue         <= '0;
            framenumber  <= '0;
            shadow_board <= '0;
            shadow_score <= '0;
        end else begin
            hsync <= hsync_c;
            vsync <= vsync_c;
            de    <= de_c;
            red   <= pix_c.r;
            green <= pix_c.g;
            blue  <= pix_c.b;
            if (frame_start_c) begin
                shadow_board <= board;
                shadow_score <= score;
                framenumber  <= framenumber + FRAME_W'(1);
            end
        end
    end

endmodule

// File: doc/board_renderer.md
BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 Parameter CELL_PX, default 16, cell edge in pixels; SHALL be a power of two.
REQ-002 Parameter ORIGIN_X, default 240, left pixel column of the board area.
REQ-003 Parameter ORIGIN_Y, default 80, top pixel row of the board area.
REQ-004 Parameter SCORE_X, default 432, left pixel column of the score strip.
REQ-005 clk  input  1  pixel clock, 25.175 MHz; one clock only; all logic on its rising edge.
REQ-006 rst_n  input  1  reset; synchronous and active-low.
REQ-007 board  input  200  playfield occupancy, bit x*20+y for x 0..9, y 0..19 (y=0 top); written by the game-logic block.
REQ-008 score  input  8  current score from the game-logic block.
REQ-009 hsync  output  1  horizontal sync, active-low.
REQ-010 vsync  output  1  vertical sync, active-low; also clocks the game-logic block.
REQ-011 de  output  1  display enable, high in the visible area.
REQ-012 red, green, blue  output  4 each  pixel colour.
REQ-013 framenumber  output  10  frame counter fed to the game-logic block.

Function
REQ-014 Horizontal counter h SHALL count 0..799, wrap to 0, 800 clocks per line.
REQ-015 Vertical counter v SHALL advance when h wraps, count 0..524, wrap to 0, 525 lines per frame.
REQ-016 Visible area SHALL be h<640 and v<480.
REQ-017 hsync SHALL be low for h 656..751; vsync SHALL be low for v 490..491; both high otherwise.
REQ-018 All outputs SHALL be registered with 1-clock latency from the (h,v) that produced them; sync, de and colour SHALL stay mutually aligned.
REQ-019 At h=0, v=480 the block SHALL latch board and score into shadow registers; rendering SHALL use only the shadow copies, so mid-frame input changes are not visible.
REQ-020 framenumber SHALL increment at h=0, v=480 and wrap 1023->0.
REQ-021 Board area: ORIGIN_X <= h < ORIGIN_X+10*CELL_PX and ORIGIN_Y <= v < ORIGIN_Y+20*CELL_PX.
REQ-022 In the board area, cx=(h-ORIGIN_X)>>log2(CELL_PX) and cy=(v-ORIGIN_Y)>>log2(CELL_PX); the cell bit is shadow[cx*20+cy].
REQ-023 Occupied cell SHALL be cyan (0,F,F); empty cell SHALL be grey (2,2,2).
REQ-024 Border: a 4-pixel ring immediately outside the board area SHALL be white (F,F,F).
REQ-025 Score strip: 8 boxes of CELL_PX x CELL_PX at v in ORIGIN_Y..ORIGIN_Y+CELL_PX-1, box k at h from SCORE_X+k*CELL_PX; box 0 shows bit 7 (MSB leftmost).
REQ-026 A score box SHALL be yellow (F,F,0) for bit 1 and grey (2,2,2) for bit 0.
REQ-027 All other visible pixels SHALL be black; when de=0, colour SHALL be 0.
REQ-028 Region priority SHALL be board > border > score > background.

Reset
REQ-029 With rst_n low at a clock edge, the following SHALL take effect on that edge, including mid-line or mid-frame:
- h, v SHALL be 0.
- hsync, vsync SHALL be 1.
- de, red, green, blue SHALL be 0.
- framenumber SHALL be 0.
- Shadow board and shadow score SHALL be 0.
REQ-030 Counting SHALL restart from h=0, v=0 on the first clock with rst_n high.

Structure
REQ-031 Shared package SHALL hold:
- timing constants (800/525, visible extents, sync start and end);
- colour constants (cyan, grey, white, yellow, black);
- BOARD_W=10 and BOARD_H=20, shared with the game-logic block.
REQ-032 One sub-module, vga_timing, SHALL own the h/v counters, raw sync, de and the frame-start strobe; board_renderer SHALL own the shadow registers, region decode and colour mux.

Verification
REQ-033 Release reset -> hsync period 800 clocks; hsync first falls 657 clocks after release and stays low 96 clocks.
REQ-034 Run 2 frames -> frame length 420000 clocks; vsync low 1600 clocks; framenumber 0->1->2; preload 1023 via forced counter -> wraps to 0.
REQ-035 board with only bit 0 set -> pixels (240..255, 80..95) cyan; (256,80) grey; (236,80) white; next frame sample taken after latch.
REQ-036 Change board from 0 to all-ones at v=200 -> current frame stays all grey; next frame all cyan.
REQ-037 score=8'b1000_0001 -> boxes at h 432..447 and 544..559 yellow; the other six grey.
REQ-038 Assert rst_n low at h=300, v=100 for 1 clock -> next cycle outputs equal REQ-029 values; hsync next falls 657 clocks after release.
